// File: rtl/fir_tcdm_rr_arbiter_pkg.sv
// Shared constants and helpers for the FIR TCDM round-robin arbiter.
package fir_tcdm_rr_arbiter_pkg;

    localparam int FIR_ARB_N_REQ_DEFAULT = 3;
    localparam int FIR_ARB_OUTSTANDING_DEFAULT = 4;
    localparam int FIR_ARB_AW_DEFAULT = 32;
    localparam int FIR_ARB_DW_DEFAULT = 32;

    localparam logic [0:0] FIR_ARB_IDLE = 1'b0;
    localparam logic [0:0] FIR_ARB_LOCKED = 1'b1;

    function automatic int fir_arb_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fir_tcdm_rr_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
module fir_arb_id_fifo
    import fir_tcdm_rr_arbiter_pkg::*;
#(
    parameter int DEPTH = FIR_ARB_OUTSTANDING_DEFAULT,
    parameter int IW = 2,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          push,
    input  logic          pop,
    input  logic [IW-1:0] wdata,
    output logic [IW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk_i) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fir_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM master port between N_REQ requesters,
// with grant lock under stall and in-order response routing.
module fir_tcdm_rr_arbiter
    import fir_tcdm_rr_arbiter_pkg::*;
#(
    parameter int N_REQ = FIR_ARB_N_REQ_DEFAULT,
    parameter int AW = FIR_ARB_AW_DEFAULT,
    parameter int DW = FIR_ARB_DW_DEFAULT,
    parameter int OUTSTANDING = FIR_ARB_OUTSTANDING_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [N_REQ-1:0]      in_req,
    output logic [N_REQ-1:0]      in_gnt,
    input  logic [N_REQ*AW-1:0]   in_add,
    input  logic [N_REQ-1:0]      in_wen,
    input  logic [N_REQ*DW/8-1:0] in_be,
    input  logic [N_REQ*DW-1:0]   in_data,
    output logic [N_REQ*DW-1:0]   in_r_data,
    output logic [N_REQ-1:0]      in_r_valid,
    output logic                  out_req,
    input  logic                  out_gnt,
    output logic [AW-1:0]         out_add,
    output logic                  out_wen,
    output logic [DW/8-1:0]       out_be,
    output logic [DW-1:0]         out_data,
    input  logic [DW-1:0]         out_r_data,
    input  logic                  out_r_valid,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = DW / 8;
    localparam int CW = $clog2(OUTSTANDING) + 1;

    typedef logic [IW-1:0] fir_arb_id_t;

    logic [0:0]    state_q;
    fir_arb_id_t   sel_q;
    fir_arb_id_t   rr_ptr_q;
    fir_arb_id_t   rr_sel;
    fir_arb_id_t   sel;
    fir_arb_id_t   head_id;
    logic          flush;
    logic          req_sel;
    logic          hs;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign flush = rst_i | clear_i;

    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx = 0;
        rr_sel = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && in_req[idx]) begin
                found = 1'b1;
                rr_sel = fir_arb_id_t'(idx);
            end
        end
    end

    // A stalled request keeps its index so address and data stay stable.
    assign sel = (state_q == FIR_ARB_LOCKED) ? sel_q : rr_sel;
    assign req_sel = (state_q == FIR_ARB_LOCKED) ? in_req[sel_q] : |in_req;

    assign out_req = req_sel & ~fifo_full & ~flush;
    assign hs = out_req & out_gnt;

    always_comb begin
        in_gnt = '0;
        if (hs)
            in_gnt[sel] = 1'b1;
    end

    always_comb begin
        out_add = '0;
        out_wen = 1'b0;
        out_be = '0;
        out_data = '0;
        if (out_req) begin
            out_add = in_add[int'(sel)*AW +: AW];
            out_wen = in_wen[sel];
            out_be = in_be[int'(sel)*BW +: BW];
            out_data = in_data[int'(sel)*DW +: DW];
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            state_q <= FIR_ARB_IDLE;
            sel_q <= '0;
            rr_ptr_q <= '0;
        end else if (hs) begin
            state_q <= FIR_ARB_IDLE;
            rr_ptr_q <= fir_arb_id_t'(fir_arb_wrap_inc(int'(sel), N_REQ));
        end else if (out_req) begin
            state_q <= FIR_ARB_LOCKED;
            sel_q <= sel;
        end else begin
            state_q <= FIR_ARB_IDLE;
        end
    end

    fir_arb_id_fifo #(
        .DEPTH (OUTSTANDING),
        .IW    (IW),
        .CW    (CW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push    (hs),
        .pop     (pop),
        .wdata   (sel),
        .rdata   (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign pop = out_r_valid & ~fifo_empty & ~flush;
    assign in_r_data = {N_REQ{out_r_data}};

    always_comb begin
        in_r_valid = '0;
        if (pop)
            in_r_valid[head_id] = 1'b1;
    end

    // A response with nothing outstanding means the environment broke protocol.
    always_ff @(posedge clk_i) begin
        if (flush)
            err_o <= 1'b0;
        else if (out_r_valid && fifo_empty)
            err_o <= 1'b1;
    end

    assign busy_o = ~flush & ((fifo_count != '0) | out_req);

endmodule

// File: tb/tb_fir_tcdm_rr_arbiter.sv
// Self-checking bench: vector table with response scoreboard,
// plus hand sequences for error and reset corner cases.
module tb_fir_tcdm_rr_arbiter;

    localparam int N = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NV = 31;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            clear_i;
    logic [N-1:0]    in_req;
    logic [N-1:0]    in_gnt;
    logic [N*AW-1:0] in_add;
    logic [N-1:0]    in_wen;
    logic [N*4-1:0]  in_be;
    logic [N*DW-1:0] in_data;
    logic [N*DW-1:0] in_r_data;
    logic [N-1:0]    in_r_valid;
    logic            out_req;
    logic            out_gnt;
    logic [AW-1:0]   out_add;
    logic            out_wen;
    logic [3:0]      out_be;
    logic [DW-1:0]   out_data;
    logic [DW-1:0]   out_r_data;
    logic            out_r_valid;
    logic            busy_o;
    logic            err_o;

    fir_tcdm_rr_arbiter #(
        .N_REQ       (N),
        .AW          (AW),
        .DW          (DW),
        .OUTSTANDING (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .in_req      (in_req),
        .in_gnt      (in_gnt),
        .in_add      (in_add),
        .in_wen      (in_wen),
        .in_be       (in_be),
        .in_data     (in_data),
        .in_r_data   (in_r_data),
        .in_r_valid  (in_r_valid),
        .out_req     (out_req),
        .out_gnt     (out_gnt),
        .out_add     (out_add),
        .out_wen     (out_wen),
        .out_be      (out_be),
        .out_data    (out_data),
        .out_r_data  (out_r_data),
        .out_r_valid (out_r_valid),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         gnt;
        logic         rv;
        logic         exp_oreq;
        logic [N-1:0] exp_gnt;
        int           exp_sel;
    } vec_t;

    vec_t        tbl [NV];
    int          sb [$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] addr [N];
    logic        wen [N];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        addr[0] = 32'h0F0;
        addr[1] = 32'h100;
        addr[2] = 32'h200;
        wen[0] = 1'b1;
        wen[1] = 1'b1;
        wen[2] = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_add[i*AW +: AW] = addr[i];
            in_wen[i] = wen[i];
            in_be[i*4 +: 4] = 4'hF;
            in_data[i*DW +: DW] = 32'hD0 + 32'(i);
        end

        // single read, then fairness under 2-cycle response latency
        tbl[0]  = '{3'b010, 1'b1, 1'b0, 1'b1, 3'b010, 1};
        tbl[1]  = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 0};
        tbl[2]  = '{3'b111, 1'b1, 1'b0, 1'b1, 3'b100, 2};
        tbl[3]  = '{3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 0};
        tbl[4]  = '{3'b111, 1'b1, 1'b1, 1'b1, 3'b010, 1};
        tbl[5]  = '{3'b111, 1'b1, 1'b1, 1'b1, 3'b100, 2};
        tbl[6]  = '{3'b111, 1'b1, 1'b1, 1'b1, 3'b001, 0};
        tbl[7]  = '{3'b111, 1'b1, 1'b1, 1'b1, 3'b010, 1};
        tbl[8]  = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 0};
        tbl[9]  = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 0};
        // walk rr pointer back to 0
        tbl[10] = '{3'b001, 1'b1, 1'b0, 1'b1, 3'b001, 0};
        tbl[11] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 0};
        tbl[12] = '{3'b100, 1'b1, 1'b0, 1'b1, 3'b100, 2};
        tbl[13] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 0};
        // stall lock on requester 2; requester 0 arrives mid-stall
        tbl[14] = '{3'b100, 1'b0, 1'b0, 1'b1, 3'b000, 2};
        tbl[15] = '{3'b101, 1'b0, 1'b0, 1'b1, 3'b000, 2};
        tbl[16] = '{3'b101, 1'b0, 1'b0, 1'b1, 3'b000, 2};
        tbl[17] = '{3'b101, 1'b1, 1'b0, 1'b1, 3'b100, 2};
        tbl[18] = '{3'b001, 1'b1, 1'b1, 1'b1, 3'b001, 0};
        tbl[19] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 0};
        // backpressure: four grants fill the FIFO
        tbl[20] = '{3'b111, 1'b1, 1'b0, 1'b1, 3'b010, 1};
        tbl[21] = '{3'b111, 1'b1, 1'b0, 1'b1, 3'b100, 2};
        tbl[22] = '{3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 0};
        tbl[23] = '{3'b111, 1'b1, 1'b0, 1'b1, 3'b010, 1};
        tbl[24] = '{3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 0};
        tbl[25] = '{3'b111, 1'b1, 1'b1, 1'b0, 3'b000, 0};
        tbl[26] = '{3'b111, 1'b1, 1'b0, 1'b1, 3'b100, 2};
        tbl[27] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 0};
        tbl[28] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 0};
        tbl[29] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 0};
        tbl[30] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 0};

        rst_i = 1'b1;
        clear_i = 1'b0;
        in_req = '0;
        out_gnt = 1'b0;
        out_r_valid = 1'b0;
        out_r_data = '0;
        tick();
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_out_req", 64'(out_req), 64'd0);
        check("rst_in_gnt", 64'(in_gnt), 64'd0);
        check("rst_r_valid", 64'(in_r_valid), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        tick();

        for (int i = 0; i < NV; i++) begin
            logic [31:0] rdat;
            logic [31:0] exp_a;
            logic        exp_busy;
            int          id;
            rdat = 32'hCAFE + 32'(i) - 32'd1;
            in_req = tbl[i].req;
            out_gnt = tbl[i].gnt;
            out_r_valid = tbl[i].rv;
            out_r_data = tbl[i].rv ? rdat : 32'h0;
            @(negedge clk);
            exp_a = tbl[i].exp_oreq ? addr[tbl[i].exp_sel] : 32'h0;
            exp_busy = (sb.size() != 0) || tbl[i].exp_oreq;
            check($sformatf("v%0d_out_req", i), 64'(out_req),
                  64'(tbl[i].exp_oreq));
            check($sformatf("v%0d_in_gnt", i), 64'(in_gnt),
                  64'(tbl[i].exp_gnt));
            check($sformatf("v%0d_out_add", i), 64'(out_add), 64'(exp_a));
            check($sformatf("v%0d_busy", i), 64'(busy_o), 64'(exp_busy));
            if (tbl[i].exp_oreq)
                check($sformatf("v%0d_out_wen", i), 64'(out_wen),
                      64'(wen[tbl[i].exp_sel]));
            if (tbl[i].rv && sb.size() > 0) begin
                id = sb.pop_front();
                check($sformatf("v%0d_r_valid", i), 64'(in_r_valid),
                      64'(1) << id);
                check($sformatf("v%0d_r_data", i),
                      64'(in_r_data[id*DW +: DW]), 64'(rdat));
            end else begin
                check($sformatf("v%0d_r_valid_idle", i),
                      64'(in_r_valid), 64'd0);
            end
            if (tbl[i].exp_gnt != '0)
                sb.push_back(tbl[i].exp_sel);
            tick();
        end
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("err_after_table", 64'(err_o), 64'd0);

        // response with nothing outstanding
        in_req = '0;
        out_gnt = 1'b0;
        out_r_valid = 1'b1;
        out_r_data = 32'hBAD;
        @(negedge clk);
        check("err_no_r_valid", 64'(in_r_valid), 64'd0);
        check("err_not_yet", 64'(err_o), 64'd0);
        tick();
        out_r_valid = 1'b0;
        @(negedge clk);
        check("err_set", 64'(err_o), 64'd1);
        tick();
        @(negedge clk);
        check("err_sticky", 64'(err_o), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("err_rst", 64'(err_o), 64'd0);
        tick();

        // reset with two transactions outstanding
        in_req = 3'b111;
        out_gnt = 1'b1;
        @(negedge clk);
        check("mid_g0", 64'(in_gnt), 64'b001);
        tick();
        @(negedge clk);
        check("mid_g1", 64'(in_gnt), 64'b010);
        tick();
        in_req = '0;
        out_gnt = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        check("mid_rst_out_req", 64'(out_req), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("mid_busy", 64'(busy_o), 64'd0);
        check("mid_r_valid", 64'(in_r_valid), 64'd0);
        in_req = 3'b111;
        #1;
        check("mid_rr0_add", 64'(out_add), 64'(addr[0]));
        check("mid_no_gnt", 64'(in_gnt), 64'd0);
        tick();
        // locked requester withdraws: out_req follows low
        in_req = 3'b110;
        @(negedge clk);
        check("drop_out_req", 64'(out_req), 64'd0);
        tick();
        @(negedge clk);
        check("drop_relock", 64'(out_req), 64'd1);
        check("drop_add", 64'(out_add), 64'(addr[1]));
        tick();
        in_req = '0;
        out_r_valid = 1'b1;
        @(negedge clk);
        check("late_no_r_valid", 64'(in_r_valid), 64'd0);
        tick();
        out_r_valid = 1'b0;
        @(negedge clk);
        check("late_err", 64'(err_o), 64'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        @(negedge clk);
        check("clear_err", 64'(err_o), 64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
